// File: rtl/buffer_fifo_segmentado_if.sv
// buffer_fifo_segmentado_if: producer/consumer bus of the segmented FIFO
interface buffer_fifo_segmentado_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEG_DEPTH = 16,
  parameter int SEGMENTS = 4
);
  localparam int CW = $clog2(SEGMENTS) + 1;
  localparam int NW = $clog2(SEGMENTS * SEG_DEPTH + 1);
  logic push, pop, save_config, data_valid;
  logic buffer_full, buffer_empty, almost_full, no_config, reconfig_busy, overflow, underflow;
  logic [DATA_WIDTH-1:0] data_in, data_out;
  logic [CW-1:0] configuration;
  logic [NW-1:0] count;
  modport master (
    output push, pop, data_in, save_config, configuration,
    input data_out, data_valid, count, buffer_full, buffer_empty, almost_full,
    no_config, reconfig_busy, overflow, underflow
  );
  modport slave (
    input push, pop, data_in, save_config, configuration,
    output data_out, data_valid, count, buffer_full, buffer_empty, almost_full,
    no_config, reconfig_busy, overflow, underflow
  );
endinterface

// File: rtl/buffer_fifo_segmentado.sv
// buffer_fifo_segmentado: run-time resizable circular FIFO with drain-before-reconfigure
module buffer_fifo_segmentado #(
  parameter int DATA_WIDTH = 8,
  parameter int SEG_DEPTH = 16,
  parameter int SEGMENTS = 4,
  parameter int ALMOST_MARGIN = 2
) (
  input logic clk,
  input logic reset,
  buffer_fifo_segmentado_if.slave bus
);
  localparam int CW = $clog2(SEGMENTS) + 1;
  localparam int NW = $clog2(SEGMENTS * SEG_DEPTH + 1);
  localparam int DEPTH = SEGMENTS * SEG_DEPTH;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {E_ESPERA_CONFIG, E_ACTIVO, E_DRENAR} state_t;
  state_t state, state_n;
  logic [NW-1:0] capacity, cap_n, count, count_n;
  logic [AW-1:0] wr_ptr, wr_n, rd_ptr, rd_n;
  logic [CW-1:0] pending, pend_n, apply_cfg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic cfg_ok, run, push_ok, pop_ok, do_apply;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p, input logic [NW-1:0] cap);
    return (NW'(p) == cap - NW'(1)) ? '0 : p + AW'(1);
  endfunction

  assign bus.count = count;
  assign bus.no_config = state == E_ESPERA_CONFIG;
  assign bus.reconfig_busy = state == E_DRENAR;

  // next state: transfer acceptance, pointer wrap, and reconfiguration (immediate or after draining)
  always_comb begin
    state_n = state;
    cap_n = capacity;
    pend_n = pending;
    wr_n = wr_ptr;
    rd_n = rd_ptr;
    cfg_ok = bus.save_config && bus.configuration <= CW'(SEGMENTS);
    run = state != E_ESPERA_CONFIG;
    pop_ok = run && bus.pop && count != '0;
    push_ok = state == E_ACTIVO && bus.push && (count < capacity || pop_ok);
    do_apply = 1'b0;
    apply_cfg = bus.configuration;
    if (push_ok) wr_n = nxt(wr_ptr, capacity);
    if (pop_ok) rd_n = nxt(rd_ptr, capacity);
    if (state == E_ESPERA_CONFIG) do_apply = cfg_ok && bus.configuration != '0;
    else if (state == E_ACTIVO && cfg_ok) begin
      do_apply = count == '0 && !bus.push;
      pend_n = bus.configuration;
      state_n = E_DRENAR;
    end else if (state == E_DRENAR) begin
      pend_n = cfg_ok ? bus.configuration : pending;
      apply_cfg = pend_n;
      do_apply = count == '0;
    end
    if (do_apply) begin
      state_n = apply_cfg == '0 ? E_ESPERA_CONFIG : E_ACTIVO;
      cap_n = NW'(apply_cfg) * NW'(SEG_DEPTH);
      wr_n = '0;
      rd_n = '0;
    end
    count_n = count + NW'(push_ok) - NW'(pop_ok);
  end

  // state, pointers, registered read port and flags computed from next-cycle occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= E_ESPERA_CONFIG;
      capacity <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pending <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.buffer_full <= 1'b0;
      bus.buffer_empty <= 1'b1;
      bus.almost_full <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      state <= state_n;
      capacity <= cap_n;
      count <= count_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      pending <= pend_n;
      if (pop_ok) bus.data_out <= mem[rd_ptr];
      bus.data_valid <= pop_ok;
      bus.buffer_full <= cap_n != '0 && count_n == cap_n;
      bus.buffer_empty <= count_n == '0;
      bus.almost_full <= cap_n != '0 && 32'(cap_n - count_n) <= ALMOST_MARGIN;
      bus.overflow <= run && bus.push && !push_ok;
      bus.underflow <= run && bus.pop && !pop_ok;
    end
  end

  // storage array, left unreset
  always_ff @(posedge clk) if (reset && push_ok) mem[wr_ptr] <= bus.data_in;
endmodule

// File: doc/buffer_fifo_segmentado.md
Name: buffer_fifo_segmentado

Overview:
- Parametrised successor of the fixed 4-segment configurable FIFO.
- A single circular store of SEGMENTS x SEG_DEPTH words; usable capacity = active_segments x SEG_DEPTH, selected at run time.
- Adds occupancy count, empty/almost-full flags, registered read with valid strobe, overflow/underflow pulses, and safe on-the-fly reconfiguration by draining.
- Sits between the pixel/sample producer and the filter datapath, as the line/window buffer.

Parameters:
DATA_WIDTH, 8, word width.
SEG_DEPTH, 16, words per segment (any value >= 2, not necessarily a power of two).
SEGMENTS, 4, maximum number of segments (>= 1).
ALMOST_MARGIN, 2, almost_full asserts when free slots <= ALMOST_MARGIN.
Derived: CW = $clog2(SEGMENTS)+1 (config width); NW = $clog2(SEGMENTS*SEG_DEPTH+1) (count width).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset: 0 sampled at posedge resets the block.
push  in  1  write request.
pop  in  1  read request.
data_in  in  DATA_WIDTH  write data.
save_config  in  1  one-cycle strobe; latch configuration.
configuration  in  CW  requested active segments: 0 = disable, 1..SEGMENTS = enable; >SEGMENTS invalid.
data_out  out  DATA_WIDTH  registered read data.
data_valid  out  1  1-cycle strobe: data_out updated by an accepted pop.
count  out  NW  words stored.
buffer_full  out  1  count == capacity and capacity != 0.
buffer_empty  out  1  count == 0.
almost_full  out  1  capacity != 0 and (capacity - count) <= ALMOST_MARGIN.
no_config  out  1  high in E_ESPERA_CONFIG.
reconfig_busy  out  1  high in E_DRENAR.
overflow  out  1  1-cycle pulse: push rejected.
underflow  out  1  1-cycle pulse: pop rejected.

Behaviour:
- Reset (reset==0 at posedge):
  - State E_ESPERA_CONFIG; capacity 0; pointers 0; count 0; pending config 0.
  - data_out 0; data_valid 0; buffer_full 0; buffer_empty 1; almost_full 0; no_config 1; reconfig_busy 0; overflow 0; underflow 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data.
- E_ESPERA_CONFIG:
  - push and pop are ignored; no overflow/underflow.
  - save_config with configuration in 1..SEGMENTS: capacity = configuration*SEG_DEPTH; go to E_ACTIVO on the next cycle.
  - configuration 0 or invalid: ignored.
- E_ACTIVO:
  - Push is accepted if count < capacity, or if the buffer is full and a pop is accepted in the same cycle.
  - Pop is accepted if count > 0.
  - Accepted pop: data_out = word at rd_ptr on the next posedge, data_valid = 1 for that one cycle (latency 1). data_out holds its value otherwise.
  - Simultaneous accepted push and pop: count unchanged.
  - Pop when empty: underflow pulse. A push in the same cycle is still accepted; no bypass, so the word becomes readable on a later pop.
  - Push when full with no pop: data dropped, overflow pulse.
  - Pointers wrap from capacity-1 to 0 (modulo capacity, not a power of two).
- save_config in E_ACTIVO with configuration 0..SEGMENTS:
  - count==0 and no push in the same cycle: new capacity applies next cycle. Configuration 0 goes to E_ESPERA_CONFIG; otherwise the state stays E_ACTIVO and pointers reset to 0.
  - Otherwise: store the pending config and go to E_DRENAR. A push in the same strobe cycle is still accepted.
- E_DRENAR:
  - All pushes are rejected with an overflow pulse. Pops proceed normally.
  - A new valid save_config overwrites the pending config.
  - The cycle after count reaches 0: apply the pending config (0 goes to E_ESPERA_CONFIG, otherwise to E_ACTIVO with new capacity and pointers 0).
- Invalid configuration (> SEGMENTS) is ignored in every state.
- Flags buffer_full, buffer_empty, almost_full and count are registered, consistent with each other, and update the cycle after the causing event.

Test Plan:
1. Reset low 2 cycles, then push=1 with save_config=0 -> no_config=1, count=0, no overflow.
2. Config 1 (capacity 16); push 0x01..0x10 -> buffer_full=1, almost_full from count 14. Push 0x11 -> overflow pulse, count stays 16. Pop 16 times -> data_out 0x01..0x10, each with data_valid one cycle after its pop.
3. Config 3 (capacity 48); 200 interleaved random push/pop, both pointers wrapping several times -> output order matches a scoreboard; count never exceeds 48.
4. Full at capacity 16, push 0xAA and pop simultaneously -> oldest word out, count stays 16, no overflow. Empty, pop alone -> underflow pulse, data_valid=0.
5. Config 4 with 5 words stored; save_config configuration=2 -> reconfig_busy=1, push rejected with overflow. After 5 pops, count=0, then next cycle capacity 32, reconfig_busy=0. 32 pushes -> buffer_full=1.
6. save_config configuration=5 (invalid) in E_ACTIVO -> no state change. configuration=0 while empty -> no_config=1 next cycle. Reset low during E_DRENAR -> all outputs return to reset values.
